crc_byteen_checker: RTL and testbench
=====================================

# crc_byteEn_checker

Receive-side counterpart of the byte-enabled CRC generator path. Accepts a packet stream in the same `din`/`byteEn`/`dlast`/`flitEn` format, where each packet carries its FCS in its last CRC_WIDTH/8 bytes. It strips the FCS and runs the payload through an internal `crc_gen_byteEn`. It then compares the computed CRC with the received FCS and reports one pass/fail result per packet, plus counters. Used in the correctness-verification tops as the loopback checker and on hardware as the RX FCS check.

## Interface
- DWIDTH, 512: flit width in bits; multiple of 8.
- CRC_WIDTH, 32: CRC width; multiple of 8, 8 ≤ CRC_WIDTH ≤ DWIDTH; elaboration error otherwise.
- PIPE_LVL, CRC_POLY, INIT, XOR_OUT, REFIN, REFOUT: passed unchanged to `crc_gen_byteEn`.
- FIFO_DEPTH, 8: expected-FCS FIFO entries; power of 2; must exceed the generator latency + 1.
- CNT_WIDTH, 32: width of the packet and error counters.
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- din  in  DWIDTH  flit data; byte 0 on the wire = din[DWIDTH-1 -: 8].
- byteEn  in  DWIDTH/8  contiguous from MSB; all ones on non-last flits.
- dlast  in  1  last flit of packet.
- flitEn  in  1  flit valid; no backpressure, back-to-back allowed.
- chk_vld  out  1  one-cycle result strobe.
- chk_ok  out  1  computed CRC == received FCS; valid with chk_vld.
- crc_rx  out  CRC_WIDTH  received FCS; valid with chk_vld.
- crc_calc  out  CRC_WIDTH  computed CRC; valid with chk_vld.
- runt_err  out  1  one-cycle pulse: packet too short to hold payload plus FCS.
- fifo_ovf  out  1  sticky; expected-FCS FIFO pushed while full.
- pkt_cnt  out  CNT_WIDTH  results issued; wraps.
- err_cnt  out  CNT_WIDTH  chk_ok=0 results plus runts; saturates.

## Operation
- C = CRC_WIDTH/8 and W = DWIDTH/8. n = popcount(byteEn) of the last flit.
- FCS byte order: the first FCS byte on the wire maps to crc_rx[CRC_WIDTH-1 -: 8].
- Strip stage: a one-flit hold register H with fields {data, byteEn, last, valid}. Each accepted flit F is handled as follows.
  - F non-last: emit H if valid; then H ← F.
  - F last, n > C: emit H if valid, as non-last. H ← F with the low C enabled bytes cleared, last=1. The FCS is taken from F's bytes n-C..n-1.
  - F last, n ≤ C, H valid and non-last: emit H as last with its byteEn trimmed to W-(C-n) bytes (always ≥ 1). The FCS is H's tail C-n bytes concatenated with F's n bytes. H ← empty.
  - F last, n ≤ C, H empty or holding a last flit: runt. Emit the pending H if any; pulse runt_err; err_cnt+1; nothing is pushed.
  - No F and H.last=1: emit H; H ← empty. A non-last H waits for the next flit.
- Each emitted flit drives `crc_gen_byteEn` directly. When a last payload flit is emitted, the captured FCS is pushed into the FIFO.
- On `crc_out_vld`: pop the FIFO head and register the compare. chk_vld, crc_calc, crc_rx, chk_ok are updated; pkt_cnt+1; err_cnt+1 if the CRCs mismatch.
- Runt accounting and a compare on the same cycle: err_cnt adds both (+2 if the compare fails).
- `crc_out_vld` with the FIFO empty (protocol violation): chk_vld=1, chk_ok=0, crc_rx=0.
- Push while the FIFO is full: the entry is dropped and fifo_ovf is set until rst.

## Timing
- Input flit to generator input: 1 cycle (H), or 0 extra cycles when a flushed last H is emitted.
- `crc_out_vld` to chk_vld: 1 cycle, registered.
- All outputs, counters, H, and FIFO pointers are 0 after rst. `crc_gen_byteEn` shares the same rst.
- Reset mid-packet: the partial packet is discarded with no result. The first flit after rst deasserts starts a new packet.
- Throughput: one flit per cycle sustained, including a single-flit packet immediately following a packet whose last flit is held in H.

## Structure
- `crc_chk_pkg`: byte-popcount function, trim-mask function (keep k MSB bytes), localparams C/W, FCS FIFO entry typedef.
- Sub-module `crc_chk_fcs_strip`: the H register, trimming, and FCS capture. It outputs the payload stream plus fcs/fcs_vld.
- The top instantiates `crc_chk_fcs_strip`, `crc_gen_byteEn`, an inline FIFO, and the compare/counter logic.

## Test plan
- CRC-32 Ethernet (poly 04C11DB7, init/xorout FFFFFFFF, refin/refout 1), DWIDTH=64. Packet "123456789"+CB F4 39 26 sent as 8 + 5 bytes → one chk_vld, chk_ok=1, crc_calc=CBF43926, pkt_cnt=1.
- Same packet with payload bit 0 flipped → chk_ok=0, crc_rx=CBF43926, err_cnt=1.
- FCS split across flits: 6-byte payload plus FCS, last flit n=2 → payload emitted as one 6-byte last flit; chk_ok=1 against the software model.
- Runt: a single flit with byteEn=8'hF0 and dlast=1 → runt_err pulse, err_cnt+1, no chk_vld.
- 1000 random-length packets sent back-to-back with flitEn held high and correct FCS → 1000 chk_vld, all chk_ok=1, err_cnt=0, fifo_ovf=0.
- rst asserted for 1 cycle mid-packet, then 5 good packets → exactly 5 results, all chk_ok=1, pkt_cnt=5.

Source files
------------

// File: rtl/crc_chk_pkg.sv
// crc_chk_pkg: default geometry and byte-mask helpers shared by the FCS checker blocks.
package crc_chk_pkg;
    localparam int W = 64;
    localparam int C = 4;
    localparam int MAX_W = 64;

    function automatic int popcnt(input logic [MAX_W-1:0] v);
        int s = 0;
        for (int i = 0; i < MAX_W; i++) s += int'(v[i]);
        return s;
    endfunction

    // Keep the k most significant bytes of a w-byte enable vector.
    function automatic logic [MAX_W-1:0] trim_mask(input int w, input int k);
        logic [MAX_W-1:0] m = '0;
        for (int i = 0; i < MAX_W; i++) m[i] = (i >= w - k) && (i < w);
        return m;
    endfunction
endpackage

// File: rtl/crc_chk_fcs_strip.sv
// crc_chk_fcs_strip: one-flit hold register that removes the trailing FCS and captures it for the compare.
module crc_chk_fcs_strip import crc_chk_pkg::*; #(
    parameter int DWIDTH = 8 * W,
    parameter int CRC_WIDTH = 8 * C
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DWIDTH-1:0]     din,
    input  logic [DWIDTH/8-1:0]   byteEn,
    input  logic                  dlast,
    input  logic                  flitEn,
    output logic [DWIDTH-1:0]     pdata,
    output logic [DWIDTH/8-1:0]   pbe,
    output logic                  plast,
    output logic                  pvld,
    output logic [CRC_WIDTH-1:0]  fcs,
    output logic                  fcs_vld,
    output logic                  runt
);
    localparam int NB = DWIDTH / 8;
    localparam int NC = CRC_WIDTH / 8;

    logic [DWIDTH-1:0]    h_data;
    logic [NB-1:0]        h_be;
    logic                 h_last, h_vld;
    logic [CRC_WIDTH-1:0] h_fcs, fsel;
    logic                 short_last, split;
    int                   n;

    // FCS bytes are the C bytes ending at byte n of F, viewed across {H, F} so a split FCS needs no extra case.
    always_comb begin
        n = popcnt(MAX_W'(byteEn));
        short_last = flitEn && dlast && n <= NC;
        split = short_last && h_vld && !h_last;
        fsel = CRC_WIDTH'(({h_data, din} << (8 * (NB + n - NC))) >> (2 * DWIDTH - CRC_WIDTH));
        pvld = h_vld && (flitEn || h_last);
        pdata = h_data;
        pbe = split ? NB'(trim_mask(NB, NB - NC + n)) : h_be;
        plast = h_last || split;
        fcs = split ? fsel : h_fcs;
        fcs_vld = pvld && plast;
        runt = short_last && !split;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_data <= '0;
            h_be <= '0;
            h_last <= 1'b0;
            h_vld <= 1'b0;
            h_fcs <= '0;
        end else if (flitEn) begin
            h_data <= din;
            h_be <= dlast ? NB'(trim_mask(NB, n - NC)) : byteEn;
            h_last <= dlast && !short_last;
            h_vld <= !short_last;
            h_fcs <= fsel;
        end else if (h_last) begin
            h_last <= 1'b0;
            h_vld <= 1'b0;
        end
    end
endmodule

// File: rtl/crc_gen_byteEn.sv
// crc_gen_byteEn: byte-enabled CRC over a flit stream; result appears PIPE_LVL+1 cycles after the last flit.
module crc_gen_byteEn #(
    parameter int DWIDTH = 512,
    parameter int CRC_WIDTH = 32,
    parameter int PIPE_LVL = 0,
    parameter logic [CRC_WIDTH-1:0] CRC_POLY = 32'h04C11DB7,
    parameter logic [CRC_WIDTH-1:0] INIT = '1,
    parameter logic [CRC_WIDTH-1:0] XOR_OUT = '1,
    parameter bit REFIN = 1'b1,
    parameter bit REFOUT = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DWIDTH-1:0]     din,
    input  logic [DWIDTH/8-1:0]   byteEn,
    input  logic                  dlast,
    input  logic                  flitEn,
    output logic [CRC_WIDTH-1:0]  crc_out,
    output logic                  crc_out_vld
);
    localparam int NB = DWIDTH / 8;

    logic [CRC_WIDTH-1:0] acc, nxt, rev, fin;
    logic [CRC_WIDTH-1:0] pc [PIPE_LVL+1];
    logic [PIPE_LVL:0]    pv;

    function automatic logic [CRC_WIDTH-1:0] step(input logic [CRC_WIDTH-1:0] c, input logic [7:0] b);
        logic [CRC_WIDTH-1:0] r = c;
        logic fb;
        for (int i = 7; i >= 0; i--) begin
            fb = r[CRC_WIDTH-1] ^ (REFIN ? b[7-i] : b[i]);
            r = {r[CRC_WIDTH-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
        end
        return r;
    endfunction

    always_comb begin
        nxt = acc;
        for (int j = 0; j < NB; j++)
            if (byteEn[NB-1-j]) nxt = step(nxt, din[DWIDTH-1-8*j -: 8]);
        for (int i = 0; i < CRC_WIDTH; i++) rev[i] = nxt[CRC_WIDTH-1-i];
        fin = (REFOUT ? rev : nxt) ^ XOR_OUT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= INIT;
            pv <= '0;
            for (int i = 0; i <= PIPE_LVL; i++) pc[i] <= '0;
        end else begin
            if (flitEn) acc <= dlast ? INIT : nxt;
            pv[0] <= flitEn && dlast;
            pc[0] <= fin;
            for (int i = 1; i <= PIPE_LVL; i++) begin
                pv[i] <= pv[i-1];
                pc[i] <= pc[i-1];
            end
        end
    end

    assign crc_out = pc[PIPE_LVL];
    assign crc_out_vld = pv[PIPE_LVL];
endmodule

// File: rtl/crc_byteen_checker.sv
// crc_byteen_checker: strips each packet's FCS, recomputes the CRC over the payload and reports pass/fail plus counters.
module crc_byteen_checker import crc_chk_pkg::*; #(
    parameter int DWIDTH = 8 * W,
    parameter int CRC_WIDTH = 8 * C,
    parameter int PIPE_LVL = 0,
    parameter logic [CRC_WIDTH-1:0] CRC_POLY = 32'h04C11DB7,
    parameter logic [CRC_WIDTH-1:0] INIT = '1,
    parameter logic [CRC_WIDTH-1:0] XOR_OUT = '1,
    parameter bit REFIN = 1'b1,
    parameter bit REFOUT = 1'b1,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DWIDTH-1:0]     din,
    input  logic [DWIDTH/8-1:0]   byteEn,
    input  logic                  dlast,
    input  logic                  flitEn,
    output logic                  chk_vld,
    output logic                  chk_ok,
    output logic [CRC_WIDTH-1:0]  crc_rx,
    output logic [CRC_WIDTH-1:0]  crc_calc,
    output logic                  runt_err,
    output logic                  fifo_ovf,
    output logic [CNT_WIDTH-1:0]  pkt_cnt,
    output logic [CNT_WIDTH-1:0]  err_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);

    if (DWIDTH % 8 != 0 || CRC_WIDTH % 8 != 0 || CRC_WIDTH < 8 || CRC_WIDTH > DWIDTH || DWIDTH > 8 * MAX_W) begin : g_bad_width
        $error("crc_byteen_checker: illegal DWIDTH/CRC_WIDTH combination");
    end
    if (FIFO_DEPTH != (1 << AW) || FIFO_DEPTH <= PIPE_LVL + 2) begin : g_bad_depth
        $error("crc_byteen_checker: FIFO_DEPTH must be a power of 2 above the generator latency + 1");
    end

    typedef logic [CRC_WIDTH-1:0] fcs_t;

    logic [DWIDTH-1:0]   pdata;
    logic [DWIDTH/8-1:0] pbe;
    logic                plast, pvld, fcs_vld, runt, crc_out_vld;
    fcs_t                fcs, crc_out, head;
    fcs_t                mem [FIFO_DEPTH];
    logic [AW:0]         wp, rp;
    logic                empty, full, bad;
    logic [CNT_WIDTH:0]  esum;

    crc_chk_fcs_strip #(.DWIDTH(DWIDTH), .CRC_WIDTH(CRC_WIDTH)) u_strip (
        .clk(clk), .rst(rst), .din(din), .byteEn(byteEn), .dlast(dlast), .flitEn(flitEn),
        .pdata(pdata), .pbe(pbe), .plast(plast), .pvld(pvld),
        .fcs(fcs), .fcs_vld(fcs_vld), .runt(runt)
    );

    crc_gen_byteEn #(
        .DWIDTH(DWIDTH), .CRC_WIDTH(CRC_WIDTH), .PIPE_LVL(PIPE_LVL), .CRC_POLY(CRC_POLY),
        .INIT(INIT), .XOR_OUT(XOR_OUT), .REFIN(REFIN), .REFOUT(REFOUT)
    ) u_gen (
        .clk(clk), .rst(rst), .din(pdata), .byteEn(pbe), .dlast(plast), .flitEn(pvld),
        .crc_out(crc_out), .crc_out_vld(crc_out_vld)
    );

    // An empty FIFO on a result is a protocol violation: report it as a failed compare against 0.
    always_comb begin
        empty = wp == rp;
        full = (wp ^ rp) == {1'b1, {AW{1'b0}}};
        head = empty ? '0 : mem[rp[AW-1:0]];
        bad = crc_out_vld && (empty || head != crc_out);
        esum = {1'b0, err_cnt} + (CNT_WIDTH+1)'(runt) + (CNT_WIDTH+1)'(bad);
    end

    always_ff @(posedge clk) begin
        if (fcs_vld && !full) mem[wp[AW-1:0]] <= fcs;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            fifo_ovf <= 1'b0;
            chk_vld <= 1'b0;
            chk_ok <= 1'b0;
            crc_rx <= '0;
            crc_calc <= '0;
            runt_err <= 1'b0;
            pkt_cnt <= '0;
            err_cnt <= '0;
        end else begin
            if (fcs_vld && !full) wp <= wp + (AW+1)'(1);
            if (crc_out_vld && !empty) rp <= rp + (AW+1)'(1);
            fifo_ovf <= fifo_ovf || (fcs_vld && full);
            chk_vld <= crc_out_vld;
            if (crc_out_vld) begin
                crc_calc <= crc_out;
                crc_rx <= head;
                chk_ok <= !bad;
                pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);
            end
            runt_err <= runt;
            err_cnt <= esum[CNT_WIDTH] ? '1 : esum[CNT_WIDTH-1:0];
        end
    end
endmodule

// File: tb/tb_crc_byteen_checker.sv
// tb_crc_byteen_checker: table, directed and random packets checked against a byte-queue CRC-32 model.
module tb_crc_byteen_checker;
    typedef logic [7:0] bq_t [$];
    typedef struct { int len; bit flip; bit exp_ok; bit exp_runt; } row_t;
    typedef struct { bit ok; logic [31:0] rx; logic [31:0] calc; } res_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic [63:0] din = '0;
    logic [7:0]  byteEn = '0;
    logic        dlast = 1'b0, flitEn = 1'b0;
    logic        chk_vld, chk_ok, runt_err, fifo_ovf;
    logic [31:0] crc_rx, crc_calc, pkt_cnt, err_cnt;

    always #5 clk = ~clk;

    crc_byteen_checker #(
        .DWIDTH(64), .CRC_WIDTH(32), .PIPE_LVL(1), .CRC_POLY(32'h04C11DB7),
        .INIT(32'hFFFFFFFF), .XOR_OUT(32'hFFFFFFFF), .REFIN(1'b1), .REFOUT(1'b1),
        .FIFO_DEPTH(8), .CNT_WIDTH(32)
    ) dut (
        .clk(clk), .rst(rst), .din(din), .byteEn(byteEn), .dlast(dlast), .flitEn(flitEn),
        .chk_vld(chk_vld), .chk_ok(chk_ok), .crc_rx(crc_rx), .crc_calc(crc_calc),
        .runt_err(runt_err), .fifo_ovf(fifo_ovf), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
    );

    int          tests = 0, fails = 0;
    int          n_res = 0, n_runt = 0, exp_pkt = 0, exp_err = 0, exp_runts = 0;
    res_t        sb [$];
    logic [31:0] last_calc = '0, last_rx = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reflected CRC-32 computed LSB-first with the mirrored polynomial.
    function automatic logic [31:0] crc32(input bq_t q, input int len);
        logic [31:0] c = '1;
        for (int i = 0; i < len; i++) begin
            c ^= {24'h0, q[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
        end
        return ~c;
    endfunction

    task automatic make_pkt(input int len, input bit rnd, input bit flip, output bq_t q);
        logic [31:0] c;
        q = {};
        if (len <= 4) begin
            for (int i = 0; i < len; i++) q.push_back(8'($urandom));
        end else begin
            for (int i = 0; i < len - 4; i++) q.push_back(rnd ? 8'($urandom) : 8'(8'h31 + i));
            c = crc32(q, len - 4);
            for (int b = 3; b >= 0; b--) q.push_back(c[8*b +: 8]);
        end
        if (flip) q[0] = q[0] ^ 8'h01;
    endtask

    task automatic expect_pkt(input bq_t q, input int ok_ovr);
        int L;
        res_t e;
        L = q.size();
        if (L <= 4) begin
            exp_err++;
            exp_runts++;
        end else begin
            e.calc = crc32(q, L - 4);
            e.rx = {q[L-4], q[L-3], q[L-2], q[L-1]};
            e.ok = (ok_ovr >= 0) ? ok_ovr[0] : (e.calc == e.rx);
            sb.push_back(e);
            exp_pkt++;
            if (!e.ok) exp_err++;
        end
    endtask

    task automatic idle(input int n);
        flitEn = 1'b0;
        dlast = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_flit(input logic [63:0] d, input logic [7:0] be, input logic last);
        din = d;
        byteEn = be;
        dlast = last;
        flitEn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input bq_t q, input int gap_pct, input int max_flits);
        int L, n, f;
        logic [63:0] d;
        logic [7:0] be;
        L = q.size();
        f = 0;
        for (int off = 0; off < L && f < max_flits; off += 8) begin
            d = {$urandom, $urandom};
            be = '0;
            n = (L - off > 8) ? 8 : L - off;
            for (int j = 0; j < n; j++) begin
                d[63-8*j -: 8] = q[off+j];
                be[7-j] = 1'b1;
            end
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) idle($urandom_range(3, 1));
            send_flit(d, be, off + 8 >= L);
            f++;
        end
    endtask

    always @(negedge clk) begin
        res_t e;
        if (!rst) begin
            if (runt_err) n_runt++;
            if (chk_vld) begin
                n_res++;
                last_calc = crc_calc;
                last_rx = crc_rx;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_result: chk_vld with nothing expected, crc_rx=%h", crc_rx);
                end else begin
                    e = sb.pop_front();
                    chk("chk_ok", 64'(chk_ok), 64'(e.ok));
                    chk("crc_rx", 64'(crc_rx), 64'(e.rx));
                    chk("crc_calc", 64'(crc_calc), 64'(e.calc));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        row_t tbl [12];
        bq_t q;
        int r0, n0, e0;
        tbl[0]  = '{13, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{13, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{10, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{4,  1'b0, 1'b0, 1'b1};
        tbl[4]  = '{5,  1'b0, 1'b1, 1'b0};
        tbl[5]  = '{8,  1'b0, 1'b1, 1'b0};
        tbl[6]  = '{9,  1'b0, 1'b1, 1'b0};
        tbl[7]  = '{12, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{16, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{2,  1'b0, 1'b0, 1'b1};
        tbl[10] = '{20, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{7,  1'b0, 1'b1, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_chk_vld", 64'(chk_vld), 64'(0));
        chk("rst_chk_ok", 64'(chk_ok), 64'(0));
        chk("rst_crc_rx", 64'(crc_rx), 64'(0));
        chk("rst_crc_calc", 64'(crc_calc), 64'(0));
        chk("rst_runt_err", 64'(runt_err), 64'(0));
        chk("rst_fifo_ovf", 64'(fifo_ovf), 64'(0));
        chk("rst_pkt_cnt", 64'(pkt_cnt), 64'(0));
        chk("rst_err_cnt", 64'(err_cnt), 64'(0));
        rst = 1'b0;
        idle(2);

        for (int i = 0; i < 12; i++) begin
            make_pkt(tbl[i].len, 1'b0, tbl[i].flip, q);
            r0 = n_res;
            n0 = n_runt;
            expect_pkt(q, tbl[i].exp_runt ? -1 : int'(tbl[i].exp_ok));
            send_pkt(q, 0, 99);
            idle(10);
            chk($sformatf("row%0d_results", i), 64'(n_res - r0), 64'(!tbl[i].exp_runt));
            chk($sformatf("row%0d_runts", i), 64'(n_runt - n0), 64'(tbl[i].exp_runt));
            chk($sformatf("row%0d_pkt_cnt", i), 64'(pkt_cnt), 64'(exp_pkt));
            chk($sformatf("row%0d_err_cnt", i), 64'(err_cnt), 64'(exp_err));
            if (i == 0) chk("check_value_calc", 64'(last_calc), 64'(32'hCBF43926));
            if (i == 1) chk("flipped_crc_rx", 64'(last_rx), 64'(32'hCBF43926));
        end

        // Back-to-back: held last flit, single-flit packet, runt behind a held last, split FCS, bad packet.
        r0 = n_res;
        n0 = n_runt;
        make_pkt(16, 1'b1, 1'b0, q); expect_pkt(q, -1); send_pkt(q, 0, 99);
        make_pkt(6, 1'b1, 1'b0, q);  expect_pkt(q, -1); send_pkt(q, 0, 99);
        make_pkt(3, 1'b1, 1'b0, q);  expect_pkt(q, -1); send_pkt(q, 0, 99);
        make_pkt(10, 1'b1, 1'b0, q); expect_pkt(q, -1); send_pkt(q, 0, 99);
        make_pkt(9, 1'b1, 1'b1, q);  expect_pkt(q, -1); send_pkt(q, 0, 99);
        idle(12);
        chk("b2b_results", 64'(n_res - r0), 64'(4));
        chk("b2b_runts", 64'(n_runt - n0), 64'(1));
        chk("b2b_err_cnt", 64'(err_cnt), 64'(exp_err));
        chk("b2b_pending", 64'(sb.size()), 64'(0));

        r0 = n_res;
        e0 = exp_err;
        for (int i = 0; i < 1000; i++) begin
            make_pkt($urandom_range(40, 5), 1'b1, 1'b0, q);
            expect_pkt(q, -1);
            send_pkt(q, 0, 99);
        end
        idle(12);
        chk("rand_results", 64'(n_res - r0), 64'(1000));
        chk("rand_err_cnt", 64'(err_cnt), 64'(e0));
        chk("rand_fifo_ovf", 64'(fifo_ovf), 64'(0));
        chk("rand_pending", 64'(sb.size()), 64'(0));

        r0 = n_res;
        n0 = n_runt;
        e0 = exp_runts;
        for (int i = 0; i < 200; i++) begin
            make_pkt($urandom_range(40, 1), 1'b1, $urandom_range(9) == 0, q);
            expect_pkt(q, -1);
            send_pkt(q, 30, 99);
            if ($urandom_range(3) == 0) idle($urandom_range(2, 1));
        end
        idle(12);
        chk("gap_runts", 64'(n_runt - n0), 64'(exp_runts - e0));
        chk("gap_pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));
        chk("gap_err_cnt", 64'(err_cnt), 64'(exp_err));
        chk("gap_pending", 64'(sb.size()), 64'(0));
        chk("gap_fifo_ovf", 64'(fifo_ovf), 64'(0));

        // Reset with two flits of a packet in flight: no result for it, counters restart.
        make_pkt(24, 1'b1, 1'b0, q);
        send_pkt(q, 0, 2);
        flitEn = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_pkt = 0;
        exp_err = 0;
        r0 = n_res;
        idle(8);
        chk("mid_rst_results", 64'(n_res - r0), 64'(0));
        chk("mid_rst_pkt_cnt", 64'(pkt_cnt), 64'(0));
        chk("mid_rst_err_cnt", 64'(err_cnt), 64'(0));
        for (int i = 0; i < 5; i++) begin
            make_pkt($urandom_range(30, 5), 1'b1, 1'b0, q);
            expect_pkt(q, -1);
            send_pkt(q, 0, 99);
        end
        idle(12);
        chk("post_rst_results", 64'(n_res - r0), 64'(5));
        chk("post_rst_pkt_cnt", 64'(pkt_cnt), 64'(5));
        chk("post_rst_err_cnt", 64'(err_cnt), 64'(0));
        chk("post_rst_pending", 64'(sb.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
